// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed LATENCY wait, single-cycle response.
// Optional misaligned-address rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_be;
  logic              cap_mis;

  logic [31:0] mem [2**ADDR_W];

  logic              handshake;
  logic              resp_fire;
  logic              src_we;
  logic [ADDR_W-1:0] src_idx;
  logic [31:0]       src_wdata;
  logic [3:0]        src_be;
  logic              src_mis;
  logic              src_err;
  logic [31:0]       mem_word;
  logic [31:0]       merged;

  // Upper address bits alias the array; the byte offset only matters with the align check.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

  assign handshake = req_valid && req_ready;

  // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_fire = (state_nxt == RESP) && (state != RESP);

  // With zero latency the response is formed on the acceptance edge, before capture.
  always_comb begin
    if (state == IDLE) begin
      src_we    = req_we;
      src_idx   = req_addr[ADDR_W+1:2];
      src_wdata = req_wdata;
      src_be    = req_be;
      src_mis   = (req_addr[1:0] != 2'b00);
    end else begin
      src_we    = cap_we;
      src_idx   = cap_idx;
      src_wdata = cap_wdata;
      src_be    = cap_be;
      src_mis   = cap_mis;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign src_err = src_mis;
`else
  assign src_err = 1'b0;
`endif

  assign mem_word = mem[src_idx];

  always_comb begin
    merged = mem_word;
    for (int b = 0; b < 4; b++) begin
      if (src_be[b]) merged[8*b +: 8] = src_wdata[8*b +: 8];
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      cap_mis   <= 1'b0;
    end else if (handshake) begin
      cap_we    <= req_we;
      cap_idx   <= req_addr[ADDR_W+1:2];
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
      cap_mis   <= (req_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (resp_fire) begin
      rsp_rdata <= src_err ? 32'd0 : merged;
      rsp_err   <= src_err;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM and survives rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && resp_fire && src_we && !src_err) begin
      mem[src_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request to the selected instance and collect its response.
  task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string tag,
                        output logic [31:0] rd, output logic er);
    int n;
    int lat;
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!(sel ? req_ready0 : req_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check({tag, " accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    lat = 0;
    while (!(sel ? rsp_valid0 : rsp_valid) && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), sel ? 32'd0 : 32'(LAT));
    rd = sel ? rsp_rdata0 : rsp_rdata;
    er = sel ? rsp_err0 : rsp_err;
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 32'(sel ? rsp_valid0 : rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] rd1;
    int          busy;
    int          seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    check("reset err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word store then load back
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "t1 store", rd, er);
    check("t1 store rdata", rd, 32'hDEADBEEF);
    check("t1 store err", 32'(er), 32'd0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, "t1 load", rd, er);
    check("t1 load rdata", rd, 32'hDEADBEEF);

    // Partial-byte merge
    do_req(0, 1, 32'h10, 32'h11223344, 4'b0101, "t2 store", rd, er);
    check("t2 merged", rd, 32'hDE22BE44);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, "t2 load", rd, er);
    check("t2 load", rd, 32'hDE22BE44);

    // Store with no byte enables leaves the word alone
    do_req(0, 1, 32'h44, 32'hA5A50F0F, 4'hF, "t2b store", rd, er);
    do_req(0, 1, 32'h44, 32'hFFFFFFFF, 4'h0, "t2b be0", rd, er);
    check("t2b be0 rdata", rd, 32'hA5A50F0F);
    do_req(0, 0, 32'h44, 32'h0, 4'h0, "t2b load", rd, er);
    check("t2b load", rd, 32'hA5A50F0F);

    // Request held while busy is ignored, then accepted on the first IDLE cycle
    req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h44;
    busy = 0;
    rd1 = 32'h0;
    while (!req_ready && busy < 20) begin
      if (rsp_valid) rd1 = rsp_rdata;
      @(posedge clk); #1; busy++;
    end
    check("t3 busy cycles", 32'(busy), 32'd3);
    check("t3 first rdata", rd1, 32'hDE22BE44);
    @(posedge clk); #1;
    req_valid = 1'b0;
    busy = 0;
    while (!rsp_valid && busy < 20) begin
      @(posedge clk); #1; busy++;
    end
    check("t3 second latency", 32'(busy), 32'(LAT));
    check("t3 second rdata", rsp_rdata, 32'hA5A50F0F);
    @(posedge clk); #1;

    // Reset during WAIT discards the pending store
    do_req(0, 1, 32'h20, 32'h0BADC0DE, 4'hF, "t4 prestore", rd, er);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t4 rst valid", 32'(rsp_valid), 32'd0);
    check("t4 rst ready", 32'(req_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("t4 no response", 32'(seen), 32'd0);
    check("t4 ready after", 32'(req_ready), 32'd1);
    do_req(0, 0, 32'h20, 32'h0, 4'h0, "t4 load", rd, er);
    check("t4 prior value", rd, 32'h0BADC0DE);

    // Address wrap modulo 256 words
    do_req(0, 1, 32'h400, 32'h12345678, 4'hF, "t5 store", rd, er);
    do_req(0, 0, 32'h000, 32'h0, 4'h0, "t5 load", rd, er);
    check("t5 wrap", rd, 32'h12345678);

    // Zero-latency instance
    do_req(1, 1, 32'h8, 32'h00000077, 4'hF, "t5 l0 store", rd, er);
    check("t5 l0 store rdata", rd, 32'h00000077);
    do_req(1, 0, 32'h8, 32'h0, 4'h0, "t5 l0 load", rd, er);
    check("t5 l0 load", rd, 32'h00000077);

    // Misaligned store to 0x13 (word 0x10 holds 0xDE22BE44)
    do_req(0, 1, 32'h13, 32'hFFFFFFFF, 4'hF, "t6 store", rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6 err", 32'(er), 32'd1);
    check("t6 rdata", rd, 32'h0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, "t6 load", rd, er);
    check("t6 word kept", rd, 32'hDE22BE44);
    check("t6 load err", 32'(er), 32'd0);
`else
    check("t6 err", 32'(er), 32'd0);
    check("t6 rdata", rd, 32'hFFFFFFFF);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, "t6 load", rd, er);
    check("t6 word written", rd, 32'hFFFFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
